// File: rtl/inst_flash_resp.sv
// Instruction-side fetch responder: serves ce/pc fetches from a 16-bit flash window,
// assembling each 32-bit word from two big-endian half-word reads into a one-entry buffer.
module inst_flash_resp #(
    parameter int          FLASH_AW = 23,
    parameter logic [7:0]  WIN_BASE = 8'h30,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic [31:0]         pc,
    input  logic                flush,
    output logic [31:0]         inst,
    output logic                stallreq,
    output logic                fetch_err,
    output logic                flash_rd,
    output logic [FLASH_AW-1:0] flash_addr,
    input  logic [15:0]         flash_rdata,
    input  logic                flash_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_HI = 2'd1,
        RD_LO = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t              state, state_n;
    logic                buf_valid, buf_valid_n;
    logic [29:0]         buf_addr, buf_addr_n;
    logic [31:0]         buf_data, buf_data_n;
    logic                discard, discard_n;
    logic [29:0]         req_addr, req_addr_n;
    logic [15:0]         hi, hi_n;
    logic                flash_rd_n;
    logic [FLASH_AW-1:0] flash_addr_n;
    logic                hit;
    logic                unused;

    // Byte offset within the word never selects anything.
    assign unused = ^pc[1:0];

    assign hit       = ce && buf_valid && (buf_addr == pc[31:2]);
    assign inst      = hit ? buf_data : NOP_INST;
    assign stallreq  = ce && !hit;
    assign fetch_err = (state == ERR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            discard    <= 1'b0;
            req_addr   <= '0;
            hi         <= '0;
            flash_rd   <= 1'b0;
            flash_addr <= '0;
        end else begin
            state      <= state_n;
            buf_valid  <= buf_valid_n;
            buf_addr   <= buf_addr_n;
            buf_data   <= buf_data_n;
            discard    <= discard_n;
            req_addr   <= req_addr_n;
            hi         <= hi_n;
            flash_rd   <= flash_rd_n;
            flash_addr <= flash_addr_n;
        end
    end

    always_comb begin
        state_n      = state;
        buf_valid_n  = buf_valid;
        buf_addr_n   = buf_addr;
        buf_data_n   = buf_data;
        discard_n    = discard;
        req_addr_n   = req_addr;
        hi_n         = hi;
        flash_rd_n   = flash_rd;
        flash_addr_n = flash_addr;

        case (state)
            IDLE: begin
                if (ce && !hit && !flush) begin
                    if (pc[31:24] != WIN_BASE) begin
                        // Illegal fetch: park a NOP for this pc so the pipeline moves on.
                        state_n     = ERR;
                        buf_addr_n  = pc[31:2];
                        buf_data_n  = NOP_INST;
                        buf_valid_n = 1'b1;
                    end else begin
                        state_n      = RD_HI;
                        req_addr_n   = pc[31:2];
                        flash_addr_n = {pc[FLASH_AW:2], 1'b0};
                        flash_rd_n   = 1'b1;
                    end
                end
            end
            RD_HI: begin
                if (flash_ack) begin
                    hi_n         = flash_rdata;
                    flash_addr_n = flash_addr + {{(FLASH_AW-1){1'b0}}, 1'b1};
                    state_n      = RD_LO;
                end
            end
            RD_LO: begin
                if (flash_ack) begin
                    flash_rd_n = 1'b0;
                    if (!discard && !flush) begin
                        buf_data_n  = {hi, flash_rdata};
                        buf_addr_n  = req_addr;
                        buf_valid_n = 1'b1;
                    end
                    discard_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            ERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // The flash handshake can never be cut short, so a flush only marks it for dropping.
        if (flush) begin
            buf_valid_n = 1'b0;
            if ((state == RD_HI) || ((state == RD_LO) && !flash_ack)) begin
                discard_n = 1'b1;
            end
        end
    end

endmodule
